// File: rtl/regfile_wr_arbiter.sv
// Write-port owner for the 32x32 register file: round-robin between ALU (A) and load (B)
// write-back, plus a zeroing sweep of r1..r(2**AW-1) after reset or on request.
//
// state | meaning
// ------+----------------------------------------------------------
// SCRUB | sweeping zeros into r1..r(2**AW-1), one register per cycle
// RUN   | arbitrating A/B write-back requests
module regfile_wr_arbiter #(
  parameter int AW             = 5,
  parameter int DW             = 32,
  parameter int SCRUB_ON_RESET = 1
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          A_VALID,
  input  logic [AW-1:0] A_REG,
  input  logic [DW-1:0] A_DATA,
  output logic          A_READY,
  input  logic          B_VALID,
  input  logic [AW-1:0] B_REG,
  input  logic [DW-1:0] B_DATA,
  output logic          B_READY,
  input  logic          SCRUB_START,
  output logic          BUSY,
  output logic [AW-1:0] WriteReg,
  output logic [DW-1:0] WriteData,
  output logic          WE
);

  typedef enum logic {SCRUB = 1'b0, RUN = 1'b1} state_t;

  state_t        state, stateNext;
  logic [AW-1:0] idx;
  logic          lastB;
  logic          grantA, grantB;
  logic          idxLast;

  assign idxLast = (idx == {AW{1'b1}});
  assign BUSY    = (state == SCRUB);
  assign A_READY = grantA;
  assign B_READY = grantB;

  // lastB records who won the previous grant; on a tie the other side wins.
  always_comb begin
    grantA    = 1'b0;
    grantB    = 1'b0;
    stateNext = state;
    case (state)
      SCRUB: begin
        if (idxLast) stateNext = RUN;
      end
      RUN: begin
        if (SCRUB_START) begin
          stateNext = SCRUB;
        end else if (CLR) begin
          if (A_VALID && (!B_VALID || lastB)) grantA = 1'b1;
          else if (B_VALID)                   grantB = 1'b1;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state     <= (SCRUB_ON_RESET != 0) ? SCRUB : RUN;
      idx       <= AW'(1);
      WE        <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      lastB     <= 1'b1;
    end else begin
      state <= stateNext;
      case (state)
        SCRUB: begin
          WE        <= 1'b1;
          WriteReg  <= idx;
          WriteData <= '0;
          idx       <= idxLast ? AW'(1) : idx + AW'(1);
        end
        RUN: begin
          if (SCRUB_START) begin
            idx <= AW'(1);
            WE  <= 1'b0;
          end else if (grantA) begin
            WriteReg  <= A_REG;
            WriteData <= A_DATA;
            WE        <= |A_REG;
            lastB     <= 1'b0;
          end else if (grantB) begin
            WriteReg  <= B_REG;
            WriteData <= B_DATA;
            WE        <= |B_REG;
            lastB     <= 1'b1;
          end else begin
            WE <= 1'b0;
          end
        end
        default: WE <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed table, sweep/reset corner sequences and
// random traffic, all checked against a transaction-level reference model.
module tb_regfile_wr_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NREG = 31;

  logic          CLK = 1'b0;
  logic          CLR;
  logic          A_VALID, B_VALID, SCRUB_START;
  logic [AW-1:0] A_REG, B_REG;
  logic [DW-1:0] A_DATA, B_DATA;
  logic          A_READY, B_READY, BUSY, WE;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] WriteData;

  always #5 CLK = ~CLK;

  regfile_wr_arbiter #(.AW(AW), .DW(DW), .SCRUB_ON_RESET(1)) dut (
    .CLK(CLK), .CLR(CLR),
    .A_VALID(A_VALID), .A_REG(A_REG), .A_DATA(A_DATA), .A_READY(A_READY),
    .B_VALID(B_VALID), .B_REG(B_REG), .B_DATA(B_DATA), .B_READY(B_READY),
    .SCRUB_START(SCRUB_START), .BUSY(BUSY),
    .WriteReg(WriteReg), .WriteData(WriteData), .WE(WE)
  );

  int nChecks = 0;
  int nErrors = 0;

  // Reference model: sweep writes still owed, next sweep target, tie preference,
  // and the expected write-port outputs.
  int            mScrubLeft;
  int            mSweep;
  logic          mPreferA;
  logic          mWE;
  logic [AW-1:0] mReg;
  logic [DW-1:0] mData;
  logic          smpAR, smpBR, smpBusy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mScrubLeft = NREG;
    mSweep     = 1;
    mPreferA   = 1'b1;
    mWE        = 1'b0;
    mReg       = '0;
    mData      = '0;
  endtask

  // One clock: drive inputs, check combinational outputs at negedge, advance model,
  // check registered outputs just after posedge.
  task automatic step(input logic clr, input logic av, input logic [AW-1:0] ar,
                      input logic [DW-1:0] ad, input logic bv, input logic [AW-1:0] br,
                      input logic [DW-1:0] bd, input logic ss);
    logic eAR, eBR, eBusy;
    CLR = clr; A_VALID = av; A_REG = ar; A_DATA = ad;
    B_VALID = bv; B_REG = br; B_DATA = bd; SCRUB_START = ss;
    eBusy = (mScrubLeft != 0);
    eAR = 1'b0;
    eBR = 1'b0;
    if (clr && mScrubLeft == 0 && !ss) begin
      if (av && bv) begin
        eAR = mPreferA;
        eBR = !mPreferA;
      end else begin
        eAR = av;
        eBR = bv;
      end
    end
    @(negedge CLK);
    smpAR = A_READY; smpBR = B_READY; smpBusy = BUSY;
    chk("a_ready", 32'(A_READY), 32'(eAR));
    chk("b_ready", 32'(B_READY), 32'(eBR));
    chk("busy", 32'(BUSY), 32'(eBusy));
    if (!clr) begin
      modelReset();
    end else if (mScrubLeft != 0) begin
      mWE = 1'b1;
      mReg = AW'(mSweep);
      mData = '0;
      mSweep++;
      mScrubLeft--;
    end else if (ss) begin
      mScrubLeft = NREG;
      mSweep = 1;
      mWE = 1'b0;
    end else if (eAR || eBR) begin
      mReg = eAR ? ar : br;
      mData = eAR ? ad : bd;
      mWE = (mReg != 0);
      mPreferA = eBR;
    end else begin
      mWE = 1'b0;
    end
    @(posedge CLK);
    #1;
    chk("we", 32'(WE), 32'(mWE));
    chk("write_reg", 32'(WriteReg), 32'(mReg));
    chk("write_data", WriteData, mData);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  typedef struct {
    logic aV; logic [AW-1:0] aR; logic [DW-1:0] aD;
    logic bV; logic [AW-1:0] bR; logic [DW-1:0] bD;
    logic eAR; logic eBR; logic eWE; logic [AW-1:0] eReg; logic [DW-1:0] eData;
  } vec_t;

  function automatic vec_t mk(input logic aV, input logic [AW-1:0] aR, input logic [DW-1:0] aD,
                              input logic bV, input logic [AW-1:0] bR, input logic [DW-1:0] bD,
                              input logic eAR, input logic eBR, input logic eWE,
                              input logic [AW-1:0] eReg, input logic [DW-1:0] eData);
    vec_t v;
    v.aV = aV; v.aR = aR; v.aD = aD; v.bV = bV; v.bR = bR; v.bD = bD;
    v.eAR = eAR; v.eBR = eBR; v.eWE = eWE; v.eReg = eReg; v.eData = eData;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    logic          rAV, rBV, rClr, rSs;
    logic [AW-1:0] rAR, rBR;
    logic [DW-1:0] rAD, rBD;

    vecs.push_back(mk(1, 3, 32'h33, 1, 4, 32'h44, 1, 0, 1, 3, 32'h33));
    vecs.push_back(mk(1, 3, 32'h33, 1, 4, 32'h44, 0, 1, 1, 4, 32'h44));
    vecs.push_back(mk(1, 3, 32'h33, 1, 4, 32'h44, 1, 0, 1, 3, 32'h33));
    vecs.push_back(mk(1, 3, 32'h33, 1, 4, 32'h44, 0, 1, 1, 4, 32'h44));
    vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 1, 5, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 0, 1, 0, 32'h1234, 0, 1, 0, 0, 32'h1234));
    vecs.push_back(mk(1, 7, 32'h77, 1, 8, 32'h88, 1, 0, 1, 7, 32'h77));
    vecs.push_back(mk(0, 0, 0, 1, 8, 32'h88, 0, 1, 1, 8, 32'h88));
    vecs.push_back(mk(1, 31, 32'hFFFFFFFF, 1, 1, 32'h11, 1, 0, 1, 31, 32'hFFFFFFFF));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h11, 0, 1, 1, 1, 32'h11));
    vecs.push_back(mk(1, 0, 32'hABCD, 0, 0, 0, 1, 0, 0, 0, 32'hABCD));

    CLR = 1'b0; A_VALID = 1'b0; B_VALID = 1'b0; SCRUB_START = 1'b0;
    A_REG = '0; B_REG = '0; A_DATA = '0; B_DATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    modelReset();

    // Reset holds READY low even with a pending request; outputs cleared.
    step(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd2, 32'h22, 1'b0);
    chk("reset_we", 32'(WE), 32'h0);

    // Post-reset sweep: r1..r31, zero data.
    for (int i = 1; i <= NREG; i++) begin
      idle();
      chk("sweep_reg", 32'(WriteReg), 32'(i));
    end

    // Directed RUN-mode table.
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].aV, vecs[i].aR, vecs[i].aD, vecs[i].bV, vecs[i].bR, vecs[i].bD, 1'b0);
      chk("tbl_a_ready", 32'(smpAR), 32'(vecs[i].eAR));
      chk("tbl_b_ready", 32'(smpBR), 32'(vecs[i].eBR));
      chk("tbl_busy", 32'(smpBusy), 32'h0);
      chk("tbl_we", 32'(WE), 32'(vecs[i].eWE));
      chk("tbl_reg", 32'(WriteReg), 32'(vecs[i].eReg));
      chk("tbl_data", WriteData, vecs[i].eData);
    end

    // SCRUB_START with A pending: A held off for the sweep, restart request ignored mid-sweep.
    step(1'b1, 1'b1, 5'd6, 32'h66, 1'b0, '0, '0, 1'b1);
    chk("ss_a_ready", 32'(smpAR), 32'h0);
    chk("ss_busy_next", 32'(BUSY), 32'h1);
    for (int i = 1; i <= NREG; i++) begin
      step(1'b1, 1'b1, 5'd6, 32'h66, 1'b0, '0, '0, (i == 15));
      chk("ss_sweep_reg", 32'(WriteReg), 32'(i));
    end
    step(1'b1, 1'b1, 5'd6, 32'h66, 1'b0, '0, '0, 1'b0);
    chk("ss_pending_a", 32'(smpAR), 32'h1);
    chk("ss_pending_reg", 32'(WriteReg), 32'h6);

    // Reset in the middle of a sweep: abandons it and restarts at r1.
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    for (int i = 1; i <= 9; i++) idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    chk("midreset_we", 32'(WE), 32'h0);
    idle();
    chk("restart_reg", 32'(WriteReg), 32'h1);
    chk("restart_we", 32'(WE), 32'h1);
    for (int i = 2; i <= NREG; i++) idle();

    // Random traffic; requesters hold REG/DATA while waiting.
    rAV = 1'b0; rBV = 1'b0; rAR = '0; rBR = '0; rAD = '0; rBD = '0;
    smpAR = 1'b0; smpBR = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (!rAV || smpAR) begin
        rAV = ($urandom_range(0, 2) != 0);
        rAR = AW'($urandom);
        rAD = $urandom;
      end
      if (!rBV || smpBR) begin
        rBV = ($urandom_range(0, 2) != 0);
        rBR = AW'($urandom);
        rBD = $urandom;
      end
      rClr = ($urandom_range(0, 199) != 0);
      rSs  = ($urandom_range(0, 79) == 0);
      step(rClr, rAV, rAR, rAD, rBV, rBR, rBD, rSs);
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
